// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad column front end.
// Compile this package before any file that imports it.
package keypad_pkg;

  // Number of keypad column lines handled by the front end.
  localparam int NUM_COLS = 4;

  // One bit per column. Active-high once inside the debounced domain.
  typedef logic [NUM_COLS-1:0] col_t;

  // Column vector with no key pressed.
  localparam col_t IDLE_COLS = 4'b0000;

  // 100 us of stability at 48 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4800;

  // Single-cycle event strobes that accompany a change of the column vector.
  typedef struct packed {
    logic press;  // idle -> some key pressed
    logic rel;    // some key pressed -> idle
  } strobe_t;

  // True when more than one column is active.
  function automatic logic is_multi(col_t c);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (c[i]) n++;
    end
    return n > 1;
  endfunction

  // Strobes for a change of the column vector from old_cols to new_cols.
  // Changes between two non-idle vectors raise no strobe.
  function automatic strobe_t classify_change(col_t old_cols, col_t new_cols);
    strobe_t s;
    s.press = (old_cols == IDLE_COLS) && (new_cols != IDLE_COLS);
    s.rel   = (old_cols != IDLE_COLS) && (new_cols == IDLE_COLS);
    return s;
  endfunction

endpackage : keypad_pkg

// File: rtl/keypad_col_debouncer_if.sv
// keypad_col_debouncer_if: pin-side input and debounced outputs of the
// keypad column front end. The slave modport is the debouncer itself; the
// master modport is whoever drives the pins and consumes the clean vector.
interface keypad_col_debouncer_if
  import keypad_pkg::*;
();

  col_t col_raw;        // active-low column pins, pulled up
  col_t col_sync;       // debounced, active-high column vector
  logic press_pulse;    // one cycle: idle -> pressed
  logic release_pulse;  // one cycle: pressed -> idle
  logic multi_key;      // more than one column active

  modport master (
    output col_raw,
    input  col_sync,
    input  press_pulse,
    input  release_pulse,
    input  multi_key
  );

  modport slave (
    input  col_raw,
    output col_sync,
    output press_pulse,
    output release_pulse,
    output multi_key
  );

endinterface : keypad_col_debouncer_if

// File: rtl/sync_2ff.sv
// sync_2ff: plain two-flop synchroniser for asynchronous pin inputs.
// Each bit is synchronised independently; no multi-bit coherency is implied.
// Both stages reset to 0 asynchronously.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two-stage shift toward the clk domain.
  // NOTE: non-blocking assignments let s1 and q update together on the edge;
  // with blocking ones q would take the new d in the same cycle and the
  // second stage would vanish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule : sync_2ff

// File: rtl/keypad_col_debouncer.sv
// keypad_col_debouncer: synchronises the four active-low keypad column pins,
// filters contact bounce and drives a clean active-high column vector plus
// press/release strobes and a multi-key flag.
//
// Build option: define KEYPAD_DEBOUNCE_EN to enable the stability filter.
// Without it the candidate stage is the output register (3-edge latency)
// and DEBOUNCE_CYCLES has no effect.
module keypad_col_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_col_debouncer_if.slave bus
);

  // Reject configurations the counter cannot represent.
  if (DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("keypad_col_debouncer: DEBOUNCE_CYCLES and CNT_W must be >= 1");
  end

  col_t    s2;            // synchronised, active-high column vector
  col_t    cand;          // candidate vector being qualified
  col_t    col_sync_cur;  // vector currently presented downstream
  col_t    col_sync_nxt;  // vector it would take on an update
  logic    update;        // col_sync changes on this edge
  strobe_t strobe_d;
  strobe_t strobe_q;

  // Pins are pulled up, so invert on the way in: 1 = column pressed.
  sync_2ff #(
    .WIDTH(NUM_COLS)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (~bus.col_raw),
    .q    (s2)
  );

`ifdef KEYPAD_DEBOUNCE_EN

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  col_t             col_sync_q;

  // Track the latest synchronised vector and count how long it has held.
  // Any change restarts the count; once full, the count holds without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= IDLE_COLS;
      cnt  <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The candidate is accepted once it has held for the full window and
  // differs from what downstream already sees.
  assign update       = (s2 == cand) && (cnt == CNT_MAX) && (col_sync_q != cand);
  assign col_sync_nxt = cand;
  assign col_sync_cur = col_sync_q;

  // Output register: follows the candidate only on an accepted update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_sync_q <= IDLE_COLS;
    end else if (update) begin
      col_sync_q <= col_sync_nxt;
    end
  end

`else

  // Filter bypassed: the candidate stage is itself the output register and
  // takes the synchronised vector every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand <= IDLE_COLS;
    end else begin
      cand <= s2;
    end
  end

  assign update       = (s2 != cand);
  assign col_sync_nxt = s2;
  assign col_sync_cur = cand;

`endif

  // Decide the strobes for the change (if any) happening on this edge.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    strobe_d = '0;
    if (update) begin
      strobe_d = classify_change(col_sync_cur, col_sync_nxt);
    end
  end

  // Register the strobes on the same edge as the vector change so they line
  // up with col_sync and last exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign bus.col_sync      = col_sync_cur;
  assign bus.press_pulse   = strobe_q.press;
  assign bus.release_pulse = strobe_q.rel;
  assign bus.multi_key     = is_multi(col_sync_cur);

endmodule : keypad_col_debouncer

// File: tb/tb_keypad_col_debouncer.sv
// tb_keypad_col_debouncer: scoreboard bench for keypad_col_debouncer.
// The driver applies one pin value per clock and pushes the expected output
// state for that edge; a monitor on the falling edge pops and compares.
// Reference rule: the synchronised vector (inverted pins, two edges late) is
// adopted by col_sync once it has been seen unchanged for NEED consecutive
// cycles; strobes mark idle<->pressed transitions of col_sync.
`timescale 1ns/1ps
module tb_keypad_col_debouncer;
  import keypad_pkg::*;

  localparam int DB = 8;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int NEED = DB + 1;
`else
  localparam int NEED = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_col_debouncer_if bus();

  keypad_col_debouncer #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    col_t cols;
    logic press;
    logic rel;
    logic multi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  col_t m_pending;  // inverted pins sampled at the previous edge
  col_t m_run_val;  // synchronised vector currently being observed
  int   m_run_len;  // how many consecutive cycles it has been observed
  col_t m_sync;     // expected col_sync

  function automatic int ones(col_t c);
    int n = 0;
    for (int i = 0; i < NUM_COLS; i++) if (c[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_pending = '0;
    m_run_val = '0;
    m_run_len = 1;
    m_sync    = '0;
  endtask

  task automatic model_edge(input col_t raw, output exp_t e);
    col_t synced;
    e = '0;
    if (m_run_len >= NEED && m_run_val != m_sync) begin
      e.press = (m_sync == 4'b0000);
      e.rel   = (m_run_val == 4'b0000);
      m_sync  = m_run_val;
    end
    synced    = m_pending;
    m_pending = ~raw;
    if (synced == m_run_val) begin
      if (m_run_len < 100000) m_run_len++;
    end else begin
      m_run_val = synced;
      m_run_len = 1;
    end
    e.cols  = m_sync;
    e.multi = (ones(m_sync) > 1);
  endtask

  // ---------------- driver ----------------
  // Apply raw for the coming edge, then record what the edge should produce.
  task automatic cycle(input col_t raw);
    exp_t e;
    bus.col_raw = raw;
    @(posedge clk);
    if (reset) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_edge(raw, e);
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic hold(input col_t raw, input int n);
    for (int i = 0; i < n; i++) cycle(raw);
  endtask

  // Assert reset between clock edges and confirm outputs clear at once.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check(tag, {bus.col_sync, bus.press_pulse, bus.release_pulse, bus.multi_key}, 32'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("col_sync",      bus.col_sync,      mon_e.cols);
        check("press_pulse",   bus.press_pulse,   mon_e.press);
        check("release_pulse", bus.release_pulse, mon_e.rel);
        check("multi_key",     bus.multi_key,     mon_e.multi);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    col_t key;
    col_t prev;
    int   len;

    model_reset();

    // Reset with a key already held on column 2.
    bus.col_raw = 4'b1011;
    #1 reset = 1'b1;
    #1;
    check("reset_immediate",
          {bus.col_sync, bus.press_pulse, bus.release_pulse, bus.multi_key}, 32'h0);
    hold(4'b1011, 3);
    reset = 1'b0;
    hold(4'b1011, DB + 6);

    // Clean release, then clean press/release on column 0.
    hold(4'b1111, DB + 6);
    hold(4'b1110, 20);
    hold(4'b1111, DB + 6);

    // Bounce: toggle every 3 cycles for 30 cycles, then settle pressed.
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 4'b1110 : 4'b1111, 3);
    hold(4'b1110, DB + 6);

    // Second key added: 0001 -> 0101 with no strobe, multi_key rises.
    hold(4'b1010, DB + 6);
    hold(4'b1111, DB + 6);

    // Highest column alone.
    hold(4'b0111, DB + 6);
    hold(4'b1111, DB + 6);

    // Reset mid-count of a stable press; key held through reset release.
    hold(4'b1101, 5);
    async_reset("reset_mid_count");
    hold(4'b1101, 2);
    reset = 1'b0;
    hold(4'b1101, DB + 6);

    // Reset while a key is already reported.
    async_reset("reset_while_pressed");
    hold(4'b1101, 2);
    reset = 1'b0;
    hold(4'b1111, DB + 6);

    // Randomised sequence: mix of short glitches and long holds.
    prev = 4'b1111;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) == 0) key = 4'b0000;
      else                           key = col_t'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) len = $urandom_range(1, NEED);
      else                           len = $urandom_range(NEED + 2, NEED + 12);
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
          hold(prev, $urandom_range(1, 2));
          hold(~key, $urandom_range(1, 2));
        end
      end
      hold(~key, len);
      prev = ~key;
    end
    hold(4'b1111, NEED + 6);

    // Let the monitor consume the last entry, then confirm nothing is left.
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_keypad_col_debouncer
